// File: rtl/fp_norm_shift_49.sv
// Normalization stage after the add/FMA datapath: left-shifts the raw mantissa so its leading one
// reaches bit 48, and adjusts the exponent. It will not shift the exponent below EMIN.
module fp_norm_shift_49 #(
   parameter int EXP_W = 10,
   parameter int EMIN  = 1,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [48:0]      in_mant,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [5:0]       in_lzc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [48:0]      out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_zero,
   output logic             out_denorm,
   output logic [TAG_W-1:0] out_tag
);

   logic                    s1_valid_q;
   logic [48:0]             s1_mant_q;
   logic [EXP_W-1:0]        s1_exp_q;
   logic [5:0]              s1_sh_q;
   logic                    s1_zero_q;
   logic [TAG_W-1:0]        s1_tag_q;

   logic                    s2_valid_q;
   logic [48:0]             out_mant_q;
   logic [EXP_W-1:0]        out_exp_q;
   logic                    out_zero_q;
   logic                    out_denorm_q;
   logic [TAG_W-1:0]        out_tag_q;

   logic                    s2_adv_s;
   logic                    s1_adv_s;
   logic signed [EXP_W:0]   room_s;
   logic [5:0]              lzc_cap_s;
   logic                    in_zero_s;
   logic [5:0]              s1_sh_d;
   logic [48:0]             shifted_s;
   logic [48:0]             out_mant_d;
   logic [EXP_W-1:0]        out_exp_d;
   logic                    out_denorm_d;

   assign s2_adv_s = !s2_valid_q || out_ready;
   assign s1_adv_s = !s1_valid_q || s2_adv_s;
   assign in_ready = s1_adv_s;

   // Shift amount: leading-zero count, limited by the distance to EMIN and by the mantissa width.
   always_comb begin
      room_s    = $signed({in_exp[EXP_W-1], in_exp}) - $signed((EXP_W+1)'(EMIN));
      lzc_cap_s = (in_lzc > 6'd48) ? 6'd48 : in_lzc;
      in_zero_s = (in_mant == 49'd0);
      if (in_zero_s || room_s[EXP_W] || (room_s == '0)) begin
         s1_sh_d = 6'd0;
      end else if (room_s > $signed({{(EXP_W-5){1'b0}}, lzc_cap_s})) begin
         s1_sh_d = lzc_cap_s;
      end else begin
         s1_sh_d = room_s[5:0];
      end
   end

   // Apply the shift; a zero mantissa yields an all-zero result with exponent 0.
   always_comb begin
      shifted_s = s1_mant_q << s1_sh_q;
      if (s1_zero_q) begin
         out_mant_d   = 49'd0;
         out_exp_d    = '0;
         out_denorm_d = 1'b0;
      end else begin
         out_mant_d   = shifted_s;
         out_exp_d    = s1_exp_q - {{(EXP_W-6){1'b0}}, s1_sh_q};
         out_denorm_d = !shifted_s[48];
      end
   end

   // Stage 1: capture the input beat and its shift amount.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mant_q  <= 49'd0;
         s1_exp_q   <= '0;
         s1_sh_q    <= 6'd0;
         s1_zero_q  <= 1'b0;
         s1_tag_q   <= '0;
      end else if (s1_adv_s) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_mant_q <= in_mant;
            s1_exp_q  <= in_exp;
            s1_sh_q   <= s1_sh_d;
            s1_zero_q <= in_zero_s;
            s1_tag_q  <= in_tag;
         end
      end
   end

   // Stage 2: output register; holds its contents while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q   <= 1'b0;
         out_mant_q   <= 49'd0;
         out_exp_q    <= '0;
         out_zero_q   <= 1'b0;
         out_denorm_q <= 1'b0;
         out_tag_q    <= '0;
      end else if (s2_adv_s) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_mant_q   <= out_mant_d;
            out_exp_q    <= out_exp_d;
            out_zero_q   <= s1_zero_q;
            out_denorm_q <= out_denorm_d;
            out_tag_q    <= s1_tag_q;
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_mant   = out_mant_q;
   assign out_exp    = out_exp_q;
   assign out_zero   = out_zero_q;
   assign out_denorm = out_denorm_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fp_norm_shift_49.sv
// Directed bench for fp_norm_shift_49: single-beat vector table, a stalled stream
// with a scoreboard, and an asynchronous reset while beats are in flight.
module tb_fp_norm_shift_49;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [48:0] in_mant;
   logic [9:0]  in_exp;
   logic [5:0]  in_lzc;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [48:0] out_mant;
   logic [9:0]  out_exp;
   logic        out_zero;
   logic        out_denorm;
   logic [7:0]  out_tag;

   int n_checks = 0;
   int n_fail   = 0;

   fp_norm_shift_49 #(.EXP_W(10), .EMIN(1), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mant(in_mant), .in_exp(in_exp), .in_lzc(in_lzc), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
      .out_denorm(out_denorm), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [48:0] mant;
      logic [9:0]  exp;
      logic [5:0]  lzc;
      logic [7:0]  tag;
      logic [48:0] e_mant;
      logic [9:0]  e_exp;
      logic        e_zero;
      logic        e_denorm;
   } vec_t;

   typedef struct {
      logic [7:0]  tag;
      logic [48:0] mant;
      logic [9:0]  exp;
   } beat_t;

   vec_t  vecs[11];
   beat_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   initial begin
      beat_t b;
      beat_t got;
      int sent, rcvd, cyc, occ, k;
      logic prev_stall;
      logic [48:0] sv_mant;
      logic [9:0]  sv_exp;
      logic [7:0]  sv_tag;

      vecs[0]  = '{49'h0_0001_0000_0000, 10'd100, 6'd16, 8'h01, 49'h1_0000_0000_0000, 10'd84,  1'b0, 1'b0};
      vecs[1]  = '{49'h0_0001_0000_0000, 10'd10,  6'd16, 8'h02, 49'h0_0200_0000_0000, 10'd1,   1'b0, 1'b1};
      vecs[2]  = '{49'h0,                10'd55,  6'd0,  8'hA5, 49'h0,                10'd0,   1'b1, 1'b0};
      vecs[3]  = '{49'h1,                10'd200, 6'd48, 8'h04, 49'h1_0000_0000_0000, 10'd152, 1'b0, 1'b0};
      vecs[4]  = '{49'h1,                10'd1,   6'd48, 8'h05, 49'h1,                10'd1,   1'b0, 1'b1};
      vecs[5]  = '{49'h0_00F0_0000_0000, 10'h3FB, 6'd9,  8'h06, 49'h0_00F0_0000_0000, 10'h3FB, 1'b0, 1'b1};
      vecs[6]  = '{49'h1_2345_6789_ABCD, 10'd7,   6'd0,  8'h07, 49'h1_2345_6789_ABCD, 10'd7,   1'b0, 1'b0};
      vecs[7]  = '{49'h1,                10'd500, 6'd63, 8'h08, 49'h1_0000_0000_0000, 10'd452, 1'b0, 1'b0};
      vecs[8]  = '{49'h1_0000_0000_0001, 10'd20,  6'd4,  8'h09, 49'h0_0000_0000_0010, 10'd16,  1'b0, 1'b1};
      vecs[9]  = '{49'h0_0100_0000_0000, 10'd9,   6'd8,  8'h0A, 49'h1_0000_0000_0000, 10'd1,   1'b0, 1'b0};
      vecs[10] = '{49'h0_8000_0000_0000, 10'd511, 6'd1,  8'h0B, 49'h1_0000_0000_0000, 10'd510, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_mant = 49'd0; in_exp = 10'd0; in_lzc = 6'd0; in_tag = 8'd0;
      #12;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_out_mant", {15'd0, out_mant}, 64'd0);
      chk("reset_out_exp", {54'd0, out_exp}, 64'd0);
      chk("reset_out_flags", {62'd0, out_zero, out_denorm}, 64'd0);
      chk("reset_out_tag", {56'd0, out_tag}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single beats, fully drained between vectors.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1;
         in_mant = vecs[i].mant; in_exp = vecs[i].exp; in_lzc = vecs[i].lzc; in_tag = vecs[i].tag;
         @(negedge clk);
         in_valid = 1'b0;
         #1 chk($sformatf("v%0d_latency_early", i), {63'd0, out_valid}, 64'd0);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("v%0d_mant", i), {15'd0, out_mant}, {15'd0, vecs[i].e_mant});
         chk($sformatf("v%0d_exp", i), {54'd0, out_exp}, {54'd0, vecs[i].e_exp});
         chk($sformatf("v%0d_zero", i), {63'd0, out_zero}, {63'd0, vecs[i].e_zero});
         chk($sformatf("v%0d_denorm", i), {63'd0, out_denorm}, {63'd0, vecs[i].e_denorm});
         chk($sformatf("v%0d_tag", i), {56'd0, out_tag}, {56'd0, vecs[i].tag});
      end

      // Stream 20 beats against a random out_ready pattern.
      @(negedge clk);
      sent = 0; rcvd = 0; cyc = 0; occ = 0; prev_stall = 1'b0;
      sv_mant = 49'd0; sv_exp = 10'd0; sv_tag = 8'd0;
      while (rcvd < 20 && cyc < 500) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 1) == 1);
         if (sent < 20) begin
            k = sent + 5;
            in_valid = 1'b1;
            in_mant = 49'd1 << k;
            in_lzc = 6'(48 - k);
            in_exp = 10'(60 + sent);
            in_tag = 8'(8'h40 + sent);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_mant", {15'd0, out_mant}, {15'd0, sv_mant});
            chk("stall_exp", {54'd0, out_exp}, {54'd0, sv_exp});
            chk("stall_tag", {56'd0, out_tag}, {56'd0, sv_tag});
         end
         chk("in_ready_rule", {63'd0, in_ready}, {63'd0, !(occ == 2 && !out_ready)});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_beat", {56'd0, out_tag}, 64'hFFFF);
            end else begin
               got = sb.pop_front();
               chk("stream_tag", {56'd0, out_tag}, {56'd0, got.tag});
               chk("stream_mant", {15'd0, out_mant}, {15'd0, got.mant});
               chk("stream_exp", {54'd0, out_exp}, {54'd0, got.exp});
            end
            rcvd++; occ--;
         end
         prev_stall = out_valid && !out_ready;
         sv_mant = out_mant; sv_exp = out_exp; sv_tag = out_tag;
         if (in_valid && in_ready) begin
            b.tag = in_tag;
            b.mant = 49'h1_0000_0000_0000;
            b.exp = 10'(60 + sent - (48 - (sent + 5)));
            sb.push_back(b);
            sent++; occ++;
         end
         cyc++;
      end
      chk("stream_all_received", 64'(rcvd), 64'd20);
      chk("stream_scoreboard_empty", 64'(sb.size()), 64'd0);

      // Reset with two beats in flight.
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0;
      in_mant = 49'h1; in_lzc = 6'd48; in_exp = 10'd100; in_tag = 8'hE1;
      @(negedge clk);
      in_tag = 8'hE2;
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("rst_pre_valid", {63'd0, out_valid}, 64'd1);
      chk("rst_pre_in_ready", {63'd0, in_ready}, 64'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1 chk("rst_no_stale", {63'd0, out_valid}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
